// File: rtl/clken_gen.sv
// clken_gen: multi-channel divided/phased clock-enable generator with relock.
// Define CLKEN_GEN_TOGGLE_OUT_EN to build the tog_out square-wave registers.
module clken_gen #(
  parameter int NUM_CH = 3,
  parameter int DIV_W = 8,
  parameter logic [NUM_CH*DIV_W-1:0] DIV_INIT = {8'd2, 8'd2, 8'd4},
  parameter logic [NUM_CH*DIV_W-1:0] PHASE_INIT = {8'd1, 8'd0, 8'd0},
  parameter int LOCK_CYCLES = 16
) (
  input  logic refclk,
  input  logic rst,
  output logic [NUM_CH-1:0] en_out,
  output logic [NUM_CH-1:0] tog_out,
  output logic locked,
  input  logic resync,
  input  logic cfg_valid,
  output logic cfg_ready,
  input  logic [(NUM_CH>1?$clog2(NUM_CH):1)-1:0] cfg_ch,
  input  logic [DIV_W-1:0] cfg_div,
  input  logic [DIV_W-1:0] cfg_phase
);

  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [CH_W:0] CH_N = (CH_W+1)'(NUM_CH);
  localparam int LW = $clog2(LOCK_CYCLES + 1);
  localparam logic [LW-1:0] LAST = LW'(LOCK_CYCLES - 1);

  typedef enum logic [1:0] {SETTLE, RUN, RECONFIG} state_t;

  state_t state_q, state_d;
  logic [LW-1:0] set_q, set_d;
  logic [DIV_W-1:0] div_q [NUM_CH];
  logic [DIV_W-1:0] ph_q [NUM_CH];
  logic [DIV_W-1:0] cnt_q [NUM_CH];
  logic [DIV_W-1:0] cnt_d [NUM_CH];
  logic [NUM_CH-1:0] en_d, en_q;
  logic locked_q;
  logic hit;

  function automatic logic [DIV_W-1:0] eff_div(input logic [DIV_W-1:0] d);
    return (d == '0) ? DIV_W'(1) : d;
  endfunction

  function automatic logic [DIV_W-1:0] eff_ph(input logic [DIV_W-1:0] d,
                                              input logic [DIV_W-1:0] p);
    return (p >= d) ? d - 1'b1 : p;
  endfunction

  // ready only while locked; out-of-range channels are consumed silently
  assign hit = cfg_valid && locked_q && ({1'b0, cfg_ch} < CH_N);

  // next-state: settle count, run, one-cycle reconfig gap
  always_comb begin
    state_d = state_q;
    set_d = set_q;
    unique case (state_q)
      SETTLE: begin
        if (set_q == LAST) begin
          state_d = RUN;
          set_d = '0;
        end else begin
          set_d = set_q + 1'b1;
        end
      end
      RUN: begin
        if (hit) state_d = RECONFIG;
        else if (resync) state_d = SETTLE;
      end
      RECONFIG: state_d = SETTLE;
      default: state_d = SETTLE;
    endcase
  end

  // state and settle counter
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      state_q <= SETTLE;
      set_q <= '0;
    end else begin
      state_q <= state_d;
      set_q <= set_d;
    end
  end

  // channel configuration, stored already clamped
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) begin
        div_q[i] <= eff_div(DIV_INIT[i*DIV_W +: DIV_W]);
        ph_q[i] <= eff_ph(eff_div(DIV_INIT[i*DIV_W +: DIV_W]),
                          PHASE_INIT[i*DIV_W +: DIV_W]);
      end
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (hit && cfg_ch == CH_W'(i)) begin
          div_q[i] <= eff_div(cfg_div);
          ph_q[i] <= eff_ph(eff_div(cfg_div), cfg_phase);
        end
      end
    end
  end

  // per-channel phase counters: zero on RUN entry, wrap at D-1
  always_comb begin
    en_d = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      cnt_d[i] = '0;
      if (state_d == RUN && state_q == RUN) begin
        if (cnt_q[i] != div_q[i] - 1'b1) cnt_d[i] = cnt_q[i] + 1'b1;
      end
      en_d[i] = (state_d == RUN) && (cnt_d[i] == ph_q[i]);
    end
  end

  // registered counters, enables and lock flag
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) cnt_q[i] <= '0;
      en_q <= '0;
      locked_q <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) cnt_q[i] <= cnt_d[i];
      en_q <= en_d;
      locked_q <= (state_d == RUN);
    end
  end

  assign en_out = en_q;
  assign locked = locked_q;
  assign cfg_ready = locked_q;

`ifdef CLKEN_GEN_TOGGLE_OUT_EN
  logic [NUM_CH-1:0] tog_d, tog_q;

  // high for the first ceil(D/2) counts: 2*cnt < D
  always_comb begin
    tog_d = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      tog_d[i] = (state_d == RUN) &&
                 ({cnt_d[i], 1'b0} < {1'b0, div_q[i]});
    end
  end

  // registered square waves
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) tog_q <= '0;
    else tog_q <= tog_d;
  end

  assign tog_out = tog_q;
`else
  assign tog_out = '0;
`endif

endmodule

// File: doc/clken_gen.md
# clken_gen

Parametrised multi-channel clock-enable generator for the `refclk` domain. It derives NUM_CH divided, phase-offset enable streams from one clock, and reports alignment on a `locked` output. Dividers and phases are reprogrammable at runtime through a valid/ready port, with an automatic relock sequence. Downstream logic uses these enables instead of extra PLL outputs wherever a rate is an integer sub-multiple of `refclk`.

## Interface

Parameters:
- NUM_CH, 3, number of enable channels (1..16)
- DIV_W, 8, width of divide and phase fields
- DIV_INIT, {8'd2, 8'd2, 8'd4}, packed reset divide values; channel i is at [i*DIV_W +: DIV_W]
- PHASE_INIT, {8'd1, 8'd0, 8'd0}, packed reset phase values, same packing
- LOCK_CYCLES, 16, settle cycles before `locked` asserts (≥1)

Ports:
- refclk  in  1  sole clock; all logic is rising-edge
- rst  in  1  asynchronous, active-high reset
- en_out  out  NUM_CH  per-channel one-cycle enable pulses
- tog_out  out  NUM_CH  per-channel divided square wave (see Configuration)
- locked  out  1  high while all channels run aligned
- resync  in  1  one-cycle request to restart alignment with the current configuration
- cfg_valid  in  1  reconfiguration request
- cfg_ready  out  1  block can accept a request
- cfg_ch  in  $clog2(NUM_CH) (min 1)  target channel
- cfg_div  in  DIV_W  new divide value
- cfg_phase  in  DIV_W  new phase value

## Operation

- Effective divide: D = max(cfg value, 1). Effective phase: P = min(phase, D-1).
- FSM states: SETTLE, RUN, RECONFIG.
- **SETTLE:**
  - Counts LOCK_CYCLES cycles.
  - en_out=0, tog_out=0, locked=0, cfg_ready=0.
  - Then goes to RUN.
- **RUN:**
  - locked=1, cfg_ready=1.
  - Per-channel counters start at 0 on the first RUN cycle, so all channels are aligned.
  - With n = RUN cycle index (first RUN cycle is n=0): en_out[i]=1 iff n mod D_i == P_i.
  - Counters wrap from D_i-1 to 0. There is no global counter, so no overflow.
- **Handshake:**
  - A transfer occurs on an edge where cfg_valid && cfg_ready.
  - If cfg_ch < NUM_CH: the new D/P are stored and the FSM goes to RECONFIG.
  - If cfg_ch ≥ NUM_CH: the transfer is consumed with no change and no relock.
- **RECONFIG:**
  - Lasts exactly 1 cycle; all outputs are 0.
  - Then goes to SETTLE.
- **resync:** when sampled high in RUN, the FSM goes to SETTLE with the configuration unchanged. It is ignored in SETTLE and RECONFIG.
- **Simultaneous resync and accepted cfg transfer:** the cfg transfer wins and the sequence proceeds via RECONFIG.
- **Reset (rst):**
  - Asynchronously forces SETTLE and reloads DIV_INIT/PHASE_INIT.
  - Clears all outputs: en_out=0, tog_out=0, locked=0, cfg_ready=0.
  - Reset mid-RUN or mid-SETTLE discards any runtime configuration.

## Timing

- All outputs are registered; none is combinational from any input.
- After rst deasserts, locked rises after LOCK_CYCLES rising edges. The first en_out pulse for channel i appears P_i cycles after locked rises.
- For an accepted transfer at edge E:
  - locked falls in the cycle after E.
  - locked stays low for exactly 1+LOCK_CYCLES cycles, then rises with all counters at 0.
- For resync sampled at edge E: locked stays low for LOCK_CYCLES cycles.
- cfg_ready equals locked at all times. At most one transfer is accepted per relock.

## Configuration

- Macro: CLKEN_GEN_TOGGLE_OUT_EN.
- Defined:
  - tog_out[i]=1 iff (n mod D_i) < ceil(D_i/2), during RUN only.
  - For D=1, tog_out[i] is constant 1 in RUN.
  - The duty window ignores phase.
- Undefined: tog_out is tied to 0 and its registers are not built. All other behaviour is identical.

## Test plan

- Reset release with defaults -> locked=1 after 16 edges; en_out[0] pulses at n=0,4,8; en_out[1] at n=0,2,4; en_out[2] at n=1,3,5.
- cfg ch1 div=3 phase=5 accepted -> locked low for 17 cycles; en_out[1] then pulses at n=2,5,8 (phase clamped to 2); en_out[0] realigned to n=0,4.
- cfg with div=0 -> treated as D=1; en_out pulses every RUN cycle.
- cfg_ch=3 with NUM_CH=3 -> handshake completes, locked stays 1, no output change.
- resync and cfg_valid asserted on the same edge in RUN -> config applied, relock takes 17 low cycles; resync alone takes 16.
- rst pulsed mid-RUN after a reconfig -> outputs 0 immediately; after release, DIV_INIT/PHASE_INIT behaviour as in scenario 1. With CLKEN_GEN_TOGGLE_OUT_EN defined, tog_out[0] reads 1,1,0,0 repeating.
